sha_target_check: RTL and testbench

Downstream neighbour of the SHA final-addition stage. Each cycle it accepts one finished 256-bit hash plus its nonce on the `en`/`H`/`nonce` strobe. It compares the hash, read as a Bitcoin little-endian 256-bit integer, against a programmable target. Winning nonces go into a one-entry result register with a valid/ready handshake toward the PS-side control logic, and the block keeps hash and dropped-result counters.

---
 rtl/sha_target_check_pkg.sv | 16 +
 rtl/sha.vh | 12 +
 rtl/sha_target_check_word_cmp.sv | 20 ++
 rtl/sha_target_check.sv | 138 +++++++++++++
 tb/tb_sha_target_check.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_target_check_pkg.sv
// Shared sizes and payload type for the hash-vs-target checker.
`include "sha.vh"

package sha_target_check_pkg;

    localparam int unsigned WORD_W    = `WORD_S;
    localparam int unsigned HASH_W    = `H_SIZE;
    localparam int unsigned NUM_WORDS = HASH_W / WORD_W;

    // Candidate result carried down the pipeline.
    typedef struct packed {
        logic [WORD_W-1:0] nonce;
        logic [HASH_W-1:0] hash;
    } cand_t;

endpackage

// File: rtl/sha.vh
// Shared SHA datapath macros: word size, hash size, word slicing and byte swap.
`ifndef SHA_VH
`define SHA_VH

`define WORD_S 32
`define H_SIZE 256
// Word i of an H_SIZE vector; word 0 sits in the least significant bits.
`define VEC_I(i) ((i)*`WORD_S) +: `WORD_S
// Reverse the four bytes of a 32-bit variable.
`define BSWAP32(x) {x[7:0], x[15:8], x[23:16], x[31:24]}

`endif

// File: rtl/sha_target_check_word_cmp.sv
// sha_word_cmp: combinational unsigned compare of one 32-bit word pair.
//   a     : word of the hash value
//   b     : matching word of the target
//   lt_c  : a < b
//   eq_c  : a == b
`include "sha.vh"

module sha_word_cmp
    import sha_target_check_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              lt_c,
    output logic              eq_c
);

    assign lt_c = (a < b);
    assign eq_c = (a == b);

endmodule

// File: rtl/sha_target_check.sv
// sha_target_check: compares finished hashes (little-endian 256-bit value)
// against a target, keeps the winning nonce/hash in a one-entry result
// register with valid/ready, and counts hashes and dropped hits.
//   clk, reset   : clock, synchronous active-low reset
//   en/H/nonce   : hash strobe, hash and its nonce (no backpressure)
//   target       : numeric 256-bit target, quasi-static
//   clr_cnt      : clear hash_cnt and miss_cnt
//   res_*        : result register and handshake
//   hash_cnt     : en strobes seen (wraps)
//   miss_cnt     : hits dropped on a full result register (saturates)
`include "sha.vh"

module sha_target_check
    import sha_target_check_pkg::*;
#(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned MISS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [HASH_W-1:0] H,
    input  logic [WORD_W-1:0] nonce,
    input  logic [HASH_W-1:0] target,
    input  logic              clr_cnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_nonce,
    output logic [HASH_W-1:0] res_hash,
    output logic [CNT_W-1:0]  hash_cnt,
    output logic [MISS_W-1:0] miss_cnt
);

    // Per-word compare results; index 0 is the most significant value word.
    logic [NUM_WORDS-1:0] lt_c;
    logic [NUM_WORDS-1:0] eq_c;

    logic                 s1_valid;
    logic [NUM_WORDS-1:0] s1_lt;
    logic [NUM_WORDS-1:0] s1_eq;
    cand_t                s1_cand;

    logic                 s2_valid;
    logic                 s2_hit;
    cand_t                s2_cand;

    logic                 hit_c;
    logic                 load_c;
    logic                 drop_c;

    // Value word i is the byte-swapped hash word i; target word i counts from the top.
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_cmp
        logic [WORD_W-1:0] h_word;
        logic [WORD_W-1:0] v_word;
        logic [WORD_W-1:0] t_word;

        assign h_word = H[`VEC_I(i)];
        assign v_word = `BSWAP32(h_word);
        assign t_word = target[HASH_W-1-WORD_W*i -: WORD_W];

        sha_word_cmp u_cmp (
            .a    (v_word),
            .b    (t_word),
            .lt_c (lt_c[i]),
            .eq_c (eq_c[i])
        );
    end

    // Lexicographic combine, least significant word first; full equality counts as a hit.
    always_comb begin
        hit_c = 1'b1;
        for (int i = int'(NUM_WORDS) - 1; i >= 0; i--) begin
            hit_c = s1_lt[i] | (s1_eq[i] & hit_c);
        end
    end

    assign load_c = s2_valid & s2_hit & (~res_valid | res_ready);
    assign drop_c = s2_valid & s2_hit & res_valid & ~res_ready;

    // Pipeline valid bits; cleared by reset so in-flight hits are discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= en;
            s2_valid <= s1_valid;
        end
    end

    // Pipeline payload; only qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_lt         <= lt_c;
            s1_eq         <= eq_c;
            s1_cand.nonce <= nonce;
            s1_cand.hash  <= H;
        end
        if (s1_valid) begin
            s2_hit  <= hit_c;
            s2_cand <= s1_cand;
        end
    end

    // One-entry result register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_nonce <= '0;
            res_hash  <= '0;
        end else if (load_c) begin
            res_valid <= 1'b1;
            res_nonce <= s2_cand.nonce;
            res_hash  <= s2_cand.hash;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Counters; clear wins over that cycle's increments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hash_cnt <= '0;
            miss_cnt <= '0;
        end else if (clr_cnt) begin
            hash_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (en) begin
                hash_cnt <= hash_cnt + CNT_W'(1);
            end
            if (drop_c && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + MISS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sha_target_check.sv
// Self-checking bench for sha_target_check: directed hashes built from
// numeric values, a queue-based reference model compared every cycle,
// and literal checks at the interesting points.
module tb_sha_target_check;

    logic         clk;
    logic         reset;
    logic         en;
    logic [255:0] H;
    logic [31:0]  nonce;
    logic [255:0] target;
    logic         clr_cnt;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic [31:0]  hash_cnt;
    logic [7:0]   miss_cnt;

    int n_vec = 0;
    int n_err = 0;

    sha_target_check #(.CNT_W(32), .MISS_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .H         (H),
        .nonce     (nonce),
        .target    (target),
        .clr_cnt   (clr_cnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_nonce (res_nonce),
        .res_hash  (res_hash),
        .hash_cnt  (hash_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Hash whose little-endian reading equals v.
    function automatic logic [255:0] mk_hash(input logic [255:0] v);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = bswap(v[255-32*i -: 32]);
        return h;
    endfunction

    function automatic logic [255:0] value_of(input logic [255:0] h);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[255-32*i -: 32] = bswap(h[32*i +: 32]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned  due;
        logic         hit;
        logic [31:0]  nonce;
        logic [255:0] hash;
    } item_t;

    item_t        q[$];
    int unsigned  cyc = 0;
    logic         m_valid = 1'b0;
    logic [31:0]  m_nonce = '0;
    logic [255:0] m_hash = '0;
    logic [31:0]  m_hcnt = '0;
    logic [7:0]   m_miss = '0;

    // Inputs change 2 time units after posedge, so at negedge they are the
    // values the next posedge samples: compare first, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("res_valid", 256'(res_valid), 256'(m_valid));
                chk("res_nonce", 256'(res_nonce), 256'(m_nonce));
                chk("res_hash", res_hash, m_hash);
                chk("hash_cnt", 256'(hash_cnt), 256'(m_hcnt));
                chk("miss_cnt", 256'(miss_cnt), 256'(m_miss));
            end
            if (!reset) begin
                q.delete();
                m_valid = 1'b0;
                m_nonce = '0;
                m_hash  = '0;
                m_hcnt  = '0;
                m_miss  = '0;
            end else begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    item_t it;
                    it = q.pop_front();
                    if (it.hit) begin
                        if (!m_valid || res_ready) begin
                            m_valid = 1'b1;
                            m_nonce = it.nonce;
                            m_hash  = it.hash;
                        end else if (!clr_cnt && m_miss != 8'd255) begin
                            m_miss = m_miss + 8'd1;
                        end
                    end else if (m_valid && res_ready) begin
                        m_valid = 1'b0;
                    end
                end else if (m_valid && res_ready) begin
                    m_valid = 1'b0;
                end
                if (clr_cnt) begin
                    m_hcnt = '0;
                    m_miss = '0;
                end else if (en) begin
                    m_hcnt = m_hcnt + 32'd1;
                end
                if (en) q.push_back('{cyc + 2, value_of(H) <= target, nonce, H});
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [255:0] v, input logic [31:0] n);
        en    = 1'b1;
        H     = mk_hash(v);
        nonce = n;
        tick();
        en    = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [255:0] t1, t3, v1, v2, vh;

    initial begin
        reset = 1'b0; en = 1'b0; H = '0; nonce = '0; target = '0;
        clr_cnt = 1'b0; res_ready = 1'b0;
        t1 = {32'h0, {224{1'b1}}};
        v1 = {32'h0, 224'h0123456789abcdef_fedcba9876543210_cafef00d_55aa55aa_00000001};
        v2 = {32'h1, 224'h0};
        t3 = 256'h00000000_0000ffff_12345678_9abcdef0_0f0f0f0f_f0f0f0f0_deadbeef_00000010;
        tick(); tick();
        chk("reset valid", 256'(res_valid), 256'd0);
        chk("reset hash_cnt", 256'(hash_cnt), 256'd0);
        chk("reset res_hash", res_hash, 256'd0);
        reset = 1'b1;
        target = t1;
        tick();

        // single hit, latency 3
        send(v1, 32'h12345678);
        chk("t1 hash_cnt", 256'(hash_cnt), 256'd1);
        tick();
        chk("t1 valid early", 256'(res_valid), 256'd0);
        tick();
        chk("t1 valid", 256'(res_valid), 256'd1);
        chk("t1 nonce", 256'(res_nonce), 256'h12345678);
        chk("t1 hash", res_hash, mk_hash(v1));
        consume();
        chk("t1 consumed", 256'(res_valid), 256'd0);

        // top word 1 > 0: miss
        send(v2, 32'h55);
        tick(); tick(); tick();
        chk("t2 no hit", 256'(res_valid), 256'd0);

        // equality boundary
        target = t3;
        tick();
        send(t3, 32'h66);
        tick(); tick();
        chk("t3 eq hit", 256'(res_valid), 256'd1);
        chk("t3 eq nonce", 256'(res_nonce), 256'h66);
        consume();
        send(t3 + 256'd1, 32'h77);
        tick(); tick(); tick();
        chk("t3 plus1 no hit", 256'(res_valid), 256'd0);
        chk("t3 nonce held", 256'(res_nonce), 256'h66);

        // three back-to-back hits, consumer stalled
        target = t1;
        tick();
        for (int n = 1; n <= 3; n++) begin
            vh = {32'h0, 224'(n)};
            en = 1'b1; H = mk_hash(vh); nonce = 32'(n);
            tick();
        end
        en = 1'b0;
        tick(); tick(); tick();
        chk("t4 nonce held", 256'(res_nonce), 256'd1);
        chk("t4 miss_cnt", 256'(miss_cnt), 256'd2);
        consume();
        chk("t4 drained", 256'(res_valid), 256'd0);

        // hit coincides with handshake
        send(v1, 32'hA);
        tick(); tick();
        send(v1 ^ 256'h5, 32'hB);
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t5 valid kept", 256'(res_valid), 256'd1);
        chk("t5 new nonce", 256'(res_nonce), 256'hB);
        chk("t5 miss same", 256'(miss_cnt), 256'd2);
        consume();

        // reset with a hit in flight
        send(v1, 32'hC);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        chk("t6 no result", 256'(res_valid), 256'd0);
        chk("t6 hash_cnt", 256'(hash_cnt), 256'd0);
        chk("t6 miss_cnt", 256'(miss_cnt), 256'd0);

        // miss saturation and clear
        send(v1, 32'hD);
        tick(); tick();
        en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            H = mk_hash(v1 ^ 256'(k)); nonce = 32'(k + 16);
            tick();
        end
        en = 1'b0;
        tick(); tick(); tick();
        chk("t7 miss sat", 256'(miss_cnt), 256'd255);
        chk("t7 hash_cnt", 256'(hash_cnt), 256'd301);
        chk("t7 nonce held", 256'(res_nonce), 256'hD);
        en = 1'b1; clr_cnt = 1'b1;
        tick();
        en = 1'b0; clr_cnt = 1'b0;
        chk("t7 clr hash", 256'(hash_cnt), 256'd0);
        chk("t7 clr miss", 256'(miss_cnt), 256'd0);
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
